mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus memory-side bus of mem_access_unit.
// The slave modport is the unit; the master modport is its environment (requester and memory).
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] Ad;
  logic [31:0] WrData;
  logic [2:0]  MemWr;
  logic [1:0]  DMcut_sel;
  logic [31:0] DM;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, DM,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, Ad, WrData, MemWr, DMcut_sel
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, DM,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, Ad, WrData, MemWr, DMcut_sel
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-transaction load/store unit: IDLE -> ACCESS -> RESP, one memory command per request.
// Optional macro MEM_ACCESS_SIGNED_LOAD_EN enables LB/LH (ops 6/7); otherwise they are illegal.
module mem_access_unit (
  input  logic             Clk,
  input  logic             Reset,
  mem_access_unit_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;
  localparam logic [2:0] OP_SH  = 3'd5;
  localparam logic [2:0] OP_LB  = 3'd6;
  localparam logic [2:0] OP_LH  = 3'd7;

  localparam logic [2:0] MEMWR_IDLE = 3'd0;
  localparam logic [2:0] MEMWR_WORD = 3'd1;
  localparam logic [2:0] MEMWR_BYTE = 3'd2;
  localparam logic [2:0] MEMWR_HALF = 3'd4;

  localparam logic [1:0] CUT_WORD = 2'd0;
  localparam logic [1:0] CUT_BYTE = 2'd1;
  localparam logic [1:0] CUT_HALF = 2'd2;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        op_word;
  logic        op_half;
  logic        op_store;
  logic        op_legal;
  logic        misaligned;
  logic        op_err;
  logic [31:0] load_data;

  always_comb begin
    op_word  = 1'b0;
    op_half  = 1'b0;
    op_store = 1'b0;
    op_legal = 1'b1;
    case (op_q)
      OP_LW:  op_word = 1'b1;
      OP_LBU: ;
      OP_LHU: op_half = 1'b1;
      OP_SW:  begin op_word = 1'b1; op_store = 1'b1; end
      OP_SB:  op_store = 1'b1;
      OP_SH:  begin op_half = 1'b1; op_store = 1'b1; end
`ifdef MEM_ACCESS_SIGNED_LOAD_EN
      OP_LB:  ;
      OP_LH:  op_half = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
    misaligned = (op_word && (addr_q[1:0] != 2'b00)) || (op_half && addr_q[0]);
    op_err     = !op_legal || misaligned;
  end

  // The memory expects byte/half accesses pre-offset to its cut window (A-3 / A-2).
  always_comb begin
    bus.Ad        = '0;
    bus.WrData    = '0;
    bus.MemWr     = MEMWR_IDLE;
    bus.DMcut_sel = CUT_WORD;
    if ((state == ACCESS) && !op_err) begin
      case (op_q)
        OP_LW: bus.Ad = addr_q;
        OP_SW: begin
          bus.Ad     = addr_q;
          bus.WrData = wdata_q;
          bus.MemWr  = MEMWR_WORD;
        end
        OP_SB: begin
          bus.Ad     = addr_q;
          bus.WrData = {24'd0, wdata_q[7:0]};
          bus.MemWr  = MEMWR_BYTE;
        end
        OP_SH: begin
          bus.Ad     = addr_q - 16'd2;
          bus.WrData = {16'd0, wdata_q[15:0]};
          bus.MemWr  = MEMWR_HALF;
        end
        OP_LBU, OP_LB: begin
          bus.Ad        = addr_q - 16'd3;
          bus.DMcut_sel = CUT_BYTE;
        end
        OP_LHU, OP_LH: begin
          bus.Ad        = addr_q - 16'd2;
          bus.DMcut_sel = CUT_HALF;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load_data = bus.DM;
`ifdef MEM_ACCESS_SIGNED_LOAD_EN
    if (op_q == OP_LB) begin
      load_data = {{24{bus.DM[7]}}, bus.DM[7:0]};
    end else if (op_q == OP_LH) begin
      load_data = {{16{bus.DM[15]}}, bus.DM[15:0]};
    end
`endif
  end

  // Response registers only change at ACCESS->RESP, so they stay stable while RESP stalls.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          err_q   <= op_err;
          rdata_q <= (op_err || op_store) ? 32'd0 : load_data;
          state   <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset/handshake
// sequences and randomized traffic checked against a byte-level reference memory model.
module tb_mem_access_unit;

  logic Clk = 1'b0;
  logic Reset;
  logic mem_fill;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Memory fixture: little-endian bytes; cut reads take the byte/half at Ad+3 / Ad+2,
  // so every correctly offset access lands on byte address A of the request.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  function automatic logic [7:0] init_byte(int i);
    return 8'(i * 7 + 3);
  endfunction

  always_comb begin
    case (bus.DMcut_sel)
      2'd1:    bus.DM = {24'd0, mem[bus.Ad + 16'd3]};
      2'd2:    bus.DM = {16'd0, mem[bus.Ad + 16'd3], mem[bus.Ad + 16'd2]};
      default: bus.DM = {mem[bus.Ad + 16'd3], mem[bus.Ad + 16'd2], mem[bus.Ad + 16'd1], mem[bus.Ad]};
    endcase
  end

  always @(posedge Clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
    end else begin
      case (bus.MemWr)
        3'd1: begin
          mem[bus.Ad]         <= bus.WrData[7:0];
          mem[bus.Ad + 16'd1] <= bus.WrData[15:8];
          mem[bus.Ad + 16'd2] <= bus.WrData[23:16];
          mem[bus.Ad + 16'd3] <= bus.WrData[31:24];
        end
        3'd2: mem[bus.Ad] <= bus.WrData[7:0];
        3'd4: begin
          mem[bus.Ad + 16'd2] <= bus.WrData[7:0];
          mem[bus.Ad + 16'd3] <= bus.WrData[15:8];
        end
        default: ;
      endcase
    end
  end

  // Reference model: architectural view of each op at byte address A.
  function automatic logic op_legal(logic [2:0] op);
`ifdef MEM_ACCESS_SIGNED_LOAD_EN
    return 1'b1;
`else
    return op <= 3'd5;
`endif
  endfunction

  function automatic int op_bytes(logic [2:0] op);
    if (op == 3'd0 || op == 3'd3) return 4;
    if (op == 3'd1 || op == 3'd4 || op == 3'd6) return 1;
    return 2;
  endfunction

  function automatic logic op_is_store(logic [2:0] op);
    return op inside {3'd3, 3'd4, 3'd5};
  endfunction

  function automatic logic model_err(logic [2:0] op, logic [15:0] addr);
    return !op_legal(op) || ((int'(addr) % op_bytes(op)) != 0);
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] op, logic [15:0] addr);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < op_bytes(op); k++) v[8*k +: 8] = ref_mem[16'(addr + 16'(k))];
    if (op == 3'd6) v = {{24{v[7]}}, v[7:0]};
    if (op == 3'd7) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_commit(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wdata);
    if (op_is_store(op) && !model_err(op, addr)) begin
      for (int k = 0; k < op_bytes(op); k++) ref_mem[16'(addr + 16'(k))] = wdata[8*k +: 8];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // Full transaction starting and ending at posedge+2 in IDLE.
  task automatic run_txn(input string tag, input logic [2:0] op, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [15:0] exp_ad, input logic [2:0] exp_memwr,
                         input logic [1:0] exp_cut, input logic [31:0] exp_wr,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    applyStimulus(op, addr, wdata);
    checkOutput({tag, ".req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    checkOutput({tag, ".req_ready_access"}, 32'(bus.req_ready), 32'd0);
    checkOutput({tag, ".MemWr"}, 32'(bus.MemWr), 32'(exp_memwr));
    if (!exp_err) begin
      checkOutput({tag, ".Ad"}, 32'(bus.Ad), 32'(exp_ad));
      if (op_is_store(op)) checkOutput({tag, ".WrData"}, bus.WrData, exp_wr);
      else                 checkOutput({tag, ".DMcut_sel"}, 32'(bus.DMcut_sel), 32'(exp_cut));
    end
    step();
    checkOutput({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    checkOutput({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    checkOutput({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    checkOutput({tag, ".MemWr_resp"}, 32'(bus.MemWr), 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      checkOutput({tag, ".rsp_valid_hold"}, 32'(bus.rsp_valid), 32'd1);
      checkOutput({tag, ".rsp_rdata_hold"}, bus.rsp_rdata, exp_rdata);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checkOutput({tag, ".rsp_valid_done"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, ".req_ready_done"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic model_txn(input string tag, input logic [2:0] op, input logic [15:0] addr,
                           input logic [31:0] wdata, input int hold);
    logic        err;
    logic        st;
    int          n;
    logic [15:0] ad;
    logic [2:0]  memwr;
    logic [1:0]  cut;
    logic [31:0] wr;
    logic [31:0] rdata;
    err   = model_err(op, addr);
    st    = op_is_store(op);
    n     = op_bytes(op);
    ad    = addr - ((!st && n == 1) ? 16'd3 : (n == 2 ? 16'd2 : 16'd0));
    memwr = (err || !st) ? 3'd0 : (n == 4 ? 3'd1 : (n == 1 ? 3'd2 : 3'd4));
    cut   = (err || st) ? 2'd0 : (n == 4 ? 2'd0 : (n == 1 ? 2'd1 : 2'd2));
    wr    = (n == 4) ? wdata : ((n == 1) ? {24'd0, wdata[7:0]} : {16'd0, wdata[15:0]});
    rdata = (err || st) ? 32'd0 : model_load(op, addr);
    run_txn(tag, op, addr, wdata, ad, memwr, cut, wr, rdata, err, hold);
    model_commit(op, addr, wdata);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [15:0] ad;
    logic [2:0]  memwr;
    logic [1:0]  cut;
    logic [31:0] wr;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    Reset         = 1'b1;
    mem_fill      = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);

    vecs.push_back('{3'd3, 16'h0010, 32'hDEADBEEF, 16'h0010, 3'd1, 2'd0, 32'hDEADBEEF, 32'h0, 1'b0});
    vecs.push_back('{3'd0, 16'h0010, 32'h0,        16'h0010, 3'd0, 2'd0, 32'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{3'd4, 16'h0021, 32'h000000A5, 16'h0021, 3'd2, 2'd0, 32'h000000A5, 32'h0, 1'b0});
    vecs.push_back('{3'd1, 16'h0021, 32'h0,        16'h001E, 3'd0, 2'd1, 32'h0, 32'h000000A5, 1'b0});
    vecs.push_back('{3'd0, 16'h0002, 32'h0,        16'h0000, 3'd0, 2'd0, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{3'd5, 16'h0040, 32'h00008001, 16'h003E, 3'd4, 2'd0, 32'h00008001, 32'h0, 1'b0});
    vecs.push_back('{3'd2, 16'h0040, 32'h0,        16'h003E, 3'd0, 2'd2, 32'h0, 32'h00008001, 1'b0});
`ifdef MEM_ACCESS_SIGNED_LOAD_EN
    vecs.push_back('{3'd7, 16'h0040, 32'h0,        16'h003E, 3'd0, 2'd2, 32'h0, 32'hFFFF8001, 1'b0});
    vecs.push_back('{3'd6, 16'h0021, 32'h0,        16'h001E, 3'd0, 2'd1, 32'h0, 32'hFFFFFFA5, 1'b0});
`else
    vecs.push_back('{3'd7, 16'h0040, 32'h0,        16'h0000, 3'd0, 2'd0, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{3'd6, 16'h0021, 32'h0,        16'h0000, 3'd0, 2'd0, 32'h0, 32'h0, 1'b1});
`endif
    vecs.push_back('{3'd5, 16'h0041, 32'h00001234, 16'h0000, 3'd0, 2'd0, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{3'd4, 16'h0023, 32'h12345678, 16'h0023, 3'd2, 2'd0, 32'h00000078, 32'h0, 1'b0});
    vecs.push_back('{3'd1, 16'h0023, 32'h0,        16'h0020, 3'd0, 2'd1, 32'h0, 32'h00000078, 1'b0});
    vecs.push_back('{3'd1, 16'h0000, 32'h0,        16'hFFFD, 3'd0, 2'd1, 32'h0, 32'h00000003, 1'b0});

    step();
    mem_fill = 1'b0;
    step();
    checkOutput("reset.req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset.rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("reset.Ad", 32'(bus.Ad), 32'd0);
    checkOutput("reset.WrData", bus.WrData, 32'd0);
    checkOutput("reset.MemWr", 32'(bus.MemWr), 32'd0);
    checkOutput("reset.DMcut_sel", 32'(bus.DMcut_sel), 32'd0);
    Reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].ad,
              vecs[i].memwr, vecs[i].cut, vecs[i].wr, vecs[i].rdata, vecs[i].err, i % 3);
      model_commit(vecs[i].op, vecs[i].addr, vecs[i].wdata);
    end
    for (int a = 0; a < 8; a++) checkOutput($sformatf("mem_intact%0d", a), 32'(mem[a]), 32'(ref_mem[a]));

    // Response stalled for five cycles, then aborted by reset while in RESP.
    applyStimulus(3'd0, 16'h0010, 32'h0);
    step();
    bus.req_valid = 1'b0;
    step();
    for (int h = 0; h < 5; h++) begin
      checkOutput("stall.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("stall.rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      checkOutput("stall.req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checkOutput("resp_reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("resp_reset.req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("resp_reset.rsp_rdata", bus.rsp_rdata, 32'd0);

    // Reset during ACCESS: the store on that edge still lands in memory.
    applyStimulus(3'd3, 16'h0080, 32'hCAFEF00D);
    step();
    bus.req_valid = 1'b0;
    checkOutput("acc_reset.MemWr_before", 32'(bus.MemWr), 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checkOutput("acc_reset.MemWr_after", 32'(bus.MemWr), 32'd0);
    checkOutput("acc_reset.Ad_after", 32'(bus.Ad), 32'd0);
    checkOutput("acc_reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("acc_reset.req_ready", 32'(bus.req_ready), 32'd1);
    model_commit(3'd3, 16'h0080, 32'hCAFEF00D);
    model_txn("acc_reset.readback", 3'd0, 16'h0080, 32'h0, 0);

    // A request waiting while the response is consumed must not be taken that cycle.
    applyStimulus(3'd0, 16'h0010, 32'h0);
    step();
    bus.req_valid = 1'b0;
    step();
    applyStimulus(3'd4, 16'h0030, 32'h0000005A);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checkOutput("b2b.req_ready_after_consume", 32'(bus.req_ready), 32'd1);
    checkOutput("b2b.MemWr_after_consume", 32'(bus.MemWr), 32'd0);
    step();
    bus.req_valid = 1'b0;
    checkOutput("b2b.MemWr_accepted", 32'(bus.MemWr), 32'd2);
    checkOutput("b2b.Ad_accepted", 32'(bus.Ad), 32'h0030);
    step();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    model_commit(3'd4, 16'h0030, 32'h0000005A);
    model_txn("b2b.readback", 3'd1, 16'h0030, 32'h0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [2:0]  op;
      logic [15:0] addr;
      op   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3))
                                         : 16'(16'h0100 + 16'($urandom_range(0, 31)));
      model_txn($sformatf("rand%0d", t), op, addr, $urandom, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
